// File: rtl/hour_min_counter.sv
// Timekeeping core: 1 Hz prescaler, hh:mm:ss counters, button-driven set mode
// for hours/minutes, and a blink enable for the field being set.
module hour_min_counter #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_mode,
  output logic       o_sec_tick,
  output logic       o_blink
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          btn_mode_prev_q;
  logic          btn_up_prev_q;
  logic          mode_evt_s;
  logic          up_evt_s;
  logic          blink_s;

  assign mode_evt_s = i_btn_mode & ~btn_mode_prev_q;
  assign up_evt_s   = i_btn_up & ~btn_up_prev_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      mode_q          <= MODE_RUN;
      pre_q           <= '0;
      hour_q          <= 6'd0;
      min_q           <= 6'd0;
      sec_q           <= 6'd0;
      tick_q          <= 1'b0;
      btn_mode_prev_q <= 1'b1;
      btn_up_prev_q   <= 1'b1;
    end else begin
      mode_q          <= mode_d;
      pre_q           <= pre_d;
      hour_q          <= hour_d;
      min_q           <= min_d;
      sec_q           <= sec_d;
      tick_q          <= tick_d;
      btn_mode_prev_q <= i_btn_mode;
      btn_up_prev_q   <= i_btn_up;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_evt_s) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_d = MODE_SET_MIN;
        MODE_SET_MIN:  mode_d = MODE_RUN;
        default:       mode_d = MODE_RUN;
      endcase
    end else begin
      mode_d = mode_q;
    end
  end

  // Mode events win over up events and second ticks on the same edge.
  always_comb begin
    pre_d  = pre_q;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;
    if (mode_evt_s) begin
      pre_d = '0;
      if (mode_q == MODE_RUN) begin
        sec_d = 6'd0;
      end else begin
        sec_d = sec_q;
      end
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (sec_q == 6'd59) begin
              sec_d = 6'd0;
              if (min_q == 6'd59) begin
                min_d = 6'd0;
                if (hour_q == 6'd23) begin
                  hour_d = 6'd0;
                end else begin
                  hour_d = hour_q + 6'd1;
                end
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
        MODE_SET_HOUR: begin
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
          if (up_evt_s) begin
            if (hour_q == 6'd23) begin
              hour_d = 6'd0;
            end else begin
              hour_d = hour_q + 6'd1;
            end
          end else begin
            hour_d = hour_q;
          end
        end
        MODE_SET_MIN: begin
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
          if (up_evt_s) begin
            if (min_q == 6'd59) begin
              min_d = 6'd0;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            min_d = min_q;
          end
        end
        default: begin
          pre_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    if (mode_q == MODE_RUN) begin
      blink_s = 1'b1;
    end else begin
      blink_s = (pre_q < PRE_HALF);
    end
  end

  assign o_hour     = hour_q;
  assign o_min      = min_q;
  assign o_sec      = sec_q;
  assign o_mode     = mode_q;
  assign o_sec_tick = tick_q;
  assign o_blink    = blink_s;

endmodule

// File: tb/tb_hour_min_counter.sv
// Self-checking bench: time-of-day reference model compared every cycle,
// directed scenarios with literal expectations, then random button traffic.
module tb_hour_min_counter;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [5:0] o_hour, o_min, o_sec;
  logic [1:0] o_mode;
  logic       o_sec_tick, o_blink;

  int errors = 0;
  int checks = 0;
  int tick_seen = 0;

  hour_min_counter #(.TICKS_PER_SEC(T)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn_mode(btn_mode), .i_btn_up(btn_up),
    .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec), .o_mode(o_mode),
    .o_sec_tick(o_sec_tick), .o_blink(o_blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time of day as seconds since midnight, plus elapsed
  // cycles since the last point where the second phase was restarted.
  int  m_tod = 0;
  int  m_mode = 0;
  int  m_cyc = 0;
  bit  m_tick = 0;
  bit  m_pm = 1, m_pu = 1;
  bit  m_valid = 0;

  always @(posedge clk) begin
    bit me, ue;
    int h, mi, s;
    if (!rst_n) begin
      m_tod = 0; m_mode = 0; m_cyc = 0; m_tick = 0; m_pm = 1; m_pu = 1;
      m_valid = 1;
    end else begin
      me = btn_mode && !m_pm;
      ue = btn_up && !m_pu;
      m_pm = btn_mode;
      m_pu = btn_up;
      m_tick = 0;
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      if (me) begin
        m_mode = (m_mode + 1) % 3;
        m_cyc = 0;
        if (m_mode == 1) m_tod = m_tod - s;
      end else begin
        m_cyc++;
        if (m_mode == 0 && (m_cyc % T) == 0) begin
          m_tick = 1;
          m_tod = (m_tod + 1) % 86400;
        end else if (m_mode == 1 && ue) begin
          m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
        end else if (m_mode == 2 && ue) begin
          m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("hour", int'(o_hour), m_tod / 3600);
      check("min", int'(o_min), (m_tod / 60) % 60);
      check("sec", int'(o_sec), m_tod % 60);
      check("mode", int'(o_mode), m_mode);
      check("sec_tick", int'(o_sec_tick), int'(m_tick));
      check("blink", int'(o_blink),
            (m_mode == 0 || (m_cyc % T) < T / 2) ? 1 : 0);
      if (o_sec_tick) tick_seen++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
  endtask

  task automatic press_up();
    btn_up = 1'b1; step();
    btn_up = 1'b0; step();
  endtask

  initial begin
    int n, t0;
    // 1: reset and tick spacing
    rst_n = 1'b0;
    step(3);
    check("reset_hour", int'(o_hour), 0);
    check("reset_sec", int'(o_sec), 0);
    check("reset_mode", int'(o_mode), 0);
    check("reset_blink", int'(o_blink), 1);
    check("reset_tick", int'(o_sec_tick), 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_sec_tick) n++;
    end
    check("t1_sec", int'(o_sec), 4);
    check("t1_ticks", n, 4);

    // 2: set 23:59 then full rollover
    press_mode();
    repeat (23) press_up();
    press_mode();
    repeat (59) press_up();
    press_mode();
    check("t2_mode_run", int'(o_mode), 0);
    step(59 * T - 1);
    check("t2_pre_hour", int'(o_hour), 23);
    check("t2_pre_min", int'(o_min), 59);
    check("t2_pre_sec", int'(o_sec), 59);
    step(T);
    check("t2_roll_hour", int'(o_hour), 0);
    check("t2_roll_min", int'(o_min), 0);
    check("t2_roll_sec", int'(o_sec), 0);
    check("t2_roll_tick", int'(o_sec_tick), 1);

    // 3: set mode, blink, field wrap
    press_mode();
    check("t3_mode1", int'(o_mode), 1);
    check("t3_sec0", int'(o_sec), 0);
    check("t3_blink_a", int'(o_blink), 1);
    step(); check("t3_blink_b", int'(o_blink), 0);
    step(); check("t3_blink_c", int'(o_blink), 0);
    step(); check("t3_blink_d", int'(o_blink), 1);
    repeat (23) press_up();
    check("t3_hour23", int'(o_hour), 23);
    repeat (2) press_up();
    check("t3_hour1", int'(o_hour), 1);
    press_mode();
    check("t3_mode2", int'(o_mode), 2);
    repeat (61) press_up();
    check("t3_min1", int'(o_min), 1);
    check("t3_hour_keep", int'(o_hour), 1);

    // 4: held button, simultaneous buttons
    btn_up = 1'b1; step(20);
    btn_up = 1'b0; step();
    check("t4_held_min", int'(o_min), 2);
    press_mode();
    press_mode();
    check("t4_mode1", int'(o_mode), 1);
    btn_mode = 1'b1; btn_up = 1'b1; step();
    btn_mode = 1'b0; btn_up = 1'b0; step();
    check("t4_simul_mode", int'(o_mode), 2);
    check("t4_simul_hour", int'(o_hour), 1);

    // 5: reset mid-set and button held across reset
    press_mode();
    press_mode();
    repeat (11) press_up();
    press_mode();
    repeat (32) press_up();
    check("t5_hour12", int'(o_hour), 12);
    check("t5_min34", int'(o_min), 34);
    rst_n = 1'b0; step();
    check("t5_rst_hour", int'(o_hour), 0);
    check("t5_rst_min", int'(o_min), 0);
    check("t5_rst_mode", int'(o_mode), 0);
    btn_mode = 1'b1; step();
    rst_n = 1'b1; step(5);
    check("t5_held_mode", int'(o_mode), 0);
    btn_mode = 1'b0; step();
    press_mode();
    check("t5_repress_mode", int'(o_mode), 1);
    press_mode();
    press_mode();

    // 6: up ignored in RUN, ticks keep spacing
    t0 = tick_seen;
    repeat (10) press_up();
    check("t6_hour", int'(o_hour), 0);
    check("t6_min", int'(o_min), 0);
    check("t6_ticks", tick_seen - t0, 5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      btn_mode = (r < 5);
      btn_up = (r >= 5 && r < 30);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; btn_mode = 1'b0; btn_up = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
